// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and opcode helper for the WISC fetch stage.
package fetch_unit_pkg;

   localparam logic [15:0] NOP_INSTR = 16'h0800;
   localparam logic [4:0]  HALT_OPC  = 5'b00000;
   localparam int unsigned OPC_HI    = 15;
   localparam int unsigned OPC_LO    = 11;

   typedef enum logic [2:0] {
      FETCH = 3'd0,
      WAIT  = 3'd1,
      HOLD  = 3'd2,
      DRAIN = 3'd3,
      HALT  = 3'd4
   } fetchState_t;

   function automatic logic isHaltInstr(input logic [15:0] instr);
      return instr[OPC_HI:OPC_LO] == HALT_OPC;
   endfunction

endpackage

// File: rtl/fetch_unit_pc_reg16.sv
// 16-bit enabled register with asynchronous active-high reset to RESET_VAL.
module pc_reg16 #(
   parameter logic [15:0] RESET_VAL = '0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] d,
   output logic [15:0] q
);

   // Load d when enabled; reset forces the parameter value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     q <= RESET_VAL;
      else if (en) q <= d;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem and
// feeds IF/ID with instruction, current PC and next PC.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirectPC,
   output logic        imemRd,
   output logic [15:0] imemAddr,
   input  logic [15:0] imemData,
   input  logic        imemDone,
   output logic        fetchValid,
   output logic [15:0] instrOut,
   output logic [15:0] currPCOut,
   output logic [15:0] nextPCOut
);

   fetchState_t state, nextState;
   logic [15:0] pc, pcNext, holdInstr, holdNext;
   logic        pcEn, holdEn;

   pc_reg16 #(.RESET_VAL(RESET_PC)) pcReg (
      .clk(clk), .rst(rst), .en(pcEn), .d(pcNext), .q(pc)
   );

   // holdInstr doubles as the killed address while draining; the two uses
   // never overlap since HOLD and DRAIN are exclusive.
   pc_reg16 #(.RESET_VAL(NOP_INSTR)) holdReg (
      .clk(clk), .rst(rst), .en(holdEn), .d(holdNext), .q(holdInstr)
   );

   assign currPCOut = pc;
   assign nextPCOut = pc + 16'd2;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= nextState;
   end

   // Next state, register updates and memory/IF-ID outputs.
   always_comb begin
      nextState  = state;
      pcEn       = 1'b0;
      pcNext     = pc;
      holdEn     = 1'b0;
      holdNext   = holdInstr;
      imemRd     = 1'b0;
      imemAddr   = pc;
      fetchValid = 1'b0;
      instrOut   = NOP_INSTR;

      case (state)
         FETCH, WAIT: begin
            imemRd = 1'b1;
            if (imemDone) begin
               fetchValid = 1'b1;
               instrOut   = imemData;
               if (!stall) begin
                  pcEn      = 1'b1;
                  pcNext    = pc + 16'd2;
                  nextState = isHaltInstr(imemData) ? HALT : FETCH;
               end else begin
                  holdEn    = 1'b1;
                  holdNext  = imemData;
                  nextState = HOLD;
               end
            end else begin
               nextState = WAIT;
            end
         end
         HOLD: begin
            fetchValid = 1'b1;
            instrOut   = holdInstr;
            if (!stall) begin
               pcEn      = 1'b1;
               pcNext    = pc + 16'd2;
               nextState = isHaltInstr(holdInstr) ? HALT : FETCH;
            end
         end
         DRAIN: begin
            imemRd   = 1'b1;
            imemAddr = holdInstr;
            if (imemDone) nextState = FETCH;
         end
         HALT: begin
            nextState = HALT;
         end
         default: nextState = FETCH;
      endcase

      if (redirect) begin
         pcEn       = 1'b1;
         pcNext     = redirectPC;
         fetchValid = 1'b0;
         instrOut   = NOP_INSTR;
         holdEn     = 1'b0;
         holdNext   = holdInstr;
         if (state == WAIT && !imemDone) begin
            holdEn    = 1'b1;
            holdNext  = pc;
            nextState = DRAIN;
         end else if (state == DRAIN && !imemDone) begin
            nextState = DRAIN;
         end else begin
            // A drain that completes alongside a redirect has nothing left
            // outstanding, so fetch resumes rather than waiting forever.
            nextState = FETCH;
         end
      end

      if (rst) begin
         imemRd     = 1'b0;
         fetchValid = 1'b0;
         instrOut   = NOP_INSTR;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, wrap/async-reset
// sequence, and randomized traffic against a behavioural reference model.
module tb_fetch_unit;

   localparam logic [15:0] NOP = 16'h0800;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirectPC = '0;
   logic [15:0] imemData = '0;
   logic        imemDone = 1'b0;

   logic        rdA, validA, rdW, validW;
   logic [15:0] addrA, instrA, currA, nextA, addrW, instrW, currW, nextW;

   int checks = 0;
   int errors = 0;

   fetch_unit #(.RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirectPC(redirectPC), .imemRd(rdA), .imemAddr(addrA),
      .imemData(imemData), .imemDone(imemDone), .fetchValid(validA),
      .instrOut(instrA), .currPCOut(currA), .nextPCOut(nextA)
   );

   fetch_unit #(.RESET_PC(16'hFFFE)) dutW (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirectPC(redirectPC), .imemRd(rdW), .imemAddr(addrW),
      .imemData(imemData), .imemDone(imemDone), .fetchValid(validW),
      .instrOut(instrW), .currPCOut(currW), .nextPCOut(nextW)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        st;
      logic        rdr;
      logic [15:0] rpc;
      logic        done;
      logic [15:0] data;
      logic        eRd;
      logic [15:0] eAddr;
      logic        eValid;
      logic [15:0] eInstr;
      logic [15:0] eCurr;
   } vec_t;

   vec_t tbl[$];

   task automatic addV(input logic st, input logic rdr, input logic [15:0] rpc,
                       input logic done, input logic [15:0] data, input logic eRd,
                       input logic [15:0] eAddr, input logic eValid,
                       input logic [15:0] eInstr, input logic [15:0] eCurr);
      vec_t v;
      v.st = st; v.rdr = rdr; v.rpc = rpc; v.done = done; v.data = data;
      v.eRd = eRd; v.eAddr = eAddr; v.eValid = eValid; v.eInstr = eInstr; v.eCurr = eCurr;
      tbl.push_back(v);
   endtask

   // Memory image for the random phase: halt words every 64 instructions.
   function automatic logic [15:0] memWord(input logic [15:0] a);
      if (a[6:1] == 6'h3F) return {5'b00000, a[10:0]};
      return 16'h4000 | {1'b0, a[7:1], 8'h00};
   endfunction

   function automatic bit haltWord(input logic [15:0] w);
      return (w >> 11) == 16'd0;
   endfunction

   // Reset both DUTs and check the values visible while rst is held.
   task automatic doReset(input string tag);
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; imemDone = 1'b0; imemData = '0;
      @(negedge clk);
      #1;
      chk({tag, ".rstRd"},    {15'd0, rdA},    16'd0);
      chk({tag, ".rstValid"}, {15'd0, validA}, 16'd0);
      chk({tag, ".rstInstr"}, instrA, NOP);
      chk({tag, ".rstCurr"},  currA,  16'h0000);
      chk({tag, ".rstNext"},  nextA,  16'h0002);
      chk({tag, ".rstCurrW"}, currW,  16'hFFFE);
      chk({tag, ".rstNextW"}, nextW,  16'h0000);
      chk({tag, ".rstRdW"},   {15'd0, rdW}, 16'd0);
   endtask

   // Behavioural model state for the random phase.
   logic [15:0] mPc, mHeldI, mDrainA;
   bit          mHalt, mHeld, mDrain, mPend;

   initial begin : main
      logic        eRd, deliver;
      logic [15:0] eAddr, eInstr, r;
      int          cnt, lat;
      bit          pRd;
      logic [15:0] pAddr;

      // ---- directed vectors from reset, RESET_PC = 0 ----
      addV(0,0,16'h0000, 1,16'h4000, 1,16'h0000, 1,16'h4000, 16'h0000);
      addV(0,0,16'h0000, 1,16'h4100, 1,16'h0002, 1,16'h4100, 16'h0002);
      addV(0,0,16'h0000, 1,16'h4200, 1,16'h0004, 1,16'h4200, 16'h0004);
      addV(0,0,16'h0000, 0,16'h0000, 1,16'h0006, 0,NOP,      16'h0006);
      addV(0,0,16'h0000, 0,16'h0000, 1,16'h0006, 0,NOP,      16'h0006);
      addV(0,0,16'h0000, 1,16'h4300, 1,16'h0006, 1,16'h4300, 16'h0006);
      addV(1,0,16'h0000, 1,16'h4400, 1,16'h0008, 1,16'h4400, 16'h0008);
      addV(1,0,16'h0000, 0,16'hFFFF, 0,16'h0000, 1,16'h4400, 16'h0008);
      addV(1,0,16'h0000, 0,16'hFFFF, 0,16'h0000, 1,16'h4400, 16'h0008);
      addV(1,0,16'h0000, 0,16'hFFFF, 0,16'h0000, 1,16'h4400, 16'h0008);
      addV(0,0,16'h0000, 0,16'hFFFF, 0,16'h0000, 1,16'h4400, 16'h0008);
      addV(0,0,16'h0000, 1,16'h4500, 1,16'h000A, 1,16'h4500, 16'h000A);
      addV(0,0,16'h0000, 0,16'h0000, 1,16'h000C, 0,NOP,      16'h000C);
      addV(0,1,16'h0100, 0,16'h0000, 1,16'h000C, 0,NOP,      16'h000C);
      addV(0,0,16'h0000, 0,16'h0000, 1,16'h000C, 0,NOP,      16'h0100);
      addV(0,0,16'h0000, 1,16'h4600, 1,16'h000C, 0,NOP,      16'h0100);
      addV(0,0,16'h0000, 1,16'h4700, 1,16'h0100, 1,16'h4700, 16'h0100);
      addV(0,1,16'h0010, 0,16'h0000, 1,16'h0102, 0,NOP,      16'h0102);
      addV(0,0,16'h0000, 1,16'h0123, 1,16'h0010, 1,16'h0123, 16'h0010);
      addV(0,0,16'h0000, 1,16'h4800, 0,16'h0000, 0,NOP,      16'h0012);
      addV(0,0,16'h0000, 0,16'h0000, 0,16'h0000, 0,NOP,      16'h0012);
      addV(0,1,16'h0020, 0,16'h0000, 0,16'h0000, 0,NOP,      16'h0012);
      addV(0,0,16'h0000, 1,16'h4900, 1,16'h0020, 1,16'h4900, 16'h0020);
      addV(0,1,16'h0200, 1,16'h4A00, 1,16'h0022, 0,NOP,      16'h0022);
      addV(0,0,16'h0000, 1,16'h4B00, 1,16'h0200, 1,16'h4B00, 16'h0200);

      doReset("dir");
      foreach (tbl[i]) begin
         @(negedge clk);
         rst = 1'b0;
         stall = tbl[i].st; redirect = tbl[i].rdr; redirectPC = tbl[i].rpc;
         imemDone = tbl[i].done; imemData = tbl[i].data;
         #1;
         chk($sformatf("v%0d.rd", i), {15'd0, rdA}, {15'd0, tbl[i].eRd});
         if (tbl[i].eRd) chk($sformatf("v%0d.addr", i), addrA, tbl[i].eAddr);
         chk($sformatf("v%0d.valid", i), {15'd0, validA}, {15'd0, tbl[i].eValid});
         chk($sformatf("v%0d.instr", i), instrA, tbl[i].eInstr);
         chk($sformatf("v%0d.curr", i), currA, tbl[i].eCurr);
         chk($sformatf("v%0d.next", i), nextA, tbl[i].eCurr + 16'd2);
      end

      // ---- wrap at RESET_PC = FFFE and asynchronous reset mid-WAIT ----
      doReset("wrap");
      @(negedge clk);
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; imemDone = 1'b1; imemData = 16'h4000;
      #1;
      chk("wrap.rd0",    {15'd0, rdW}, 16'd1);
      chk("wrap.addr0",  addrW, 16'hFFFE);
      chk("wrap.valid0", {15'd0, validW}, 16'd1);
      chk("wrap.instr0", instrW, 16'h4000);
      chk("wrap.curr0",  currW, 16'hFFFE);
      chk("wrap.next0",  nextW, 16'h0000);
      @(negedge clk);
      imemDone = 1'b0; imemData = 16'h0000;
      #1;
      chk("wrap.addr1",  addrW, 16'h0000);
      chk("wrap.curr1",  currW, 16'h0000);
      chk("wrap.next1",  nextW, 16'h0002);
      chk("wrap.valid1", {15'd0, validW}, 16'd0);
      @(negedge clk);
      #1;
      chk("wrap.waitRd",   {15'd0, rdW}, 16'd1);
      chk("wrap.waitAddr", addrW, 16'h0000);
      #1 rst = 1'b1;
      #1;
      chk("wrap.arstCurr",  currW, 16'hFFFE);
      chk("wrap.arstNext",  nextW, 16'h0000);
      chk("wrap.arstRd",    {15'd0, rdW}, 16'd0);
      chk("wrap.arstValid", {15'd0, validW}, 16'd0);
      @(negedge clk);
      rst = 1'b0; imemDone = 1'b1; imemData = 16'h4100;
      #1;
      chk("wrap.reAddr",  addrW, 16'hFFFE);
      chk("wrap.reValid", {15'd0, validW}, 16'd1);
      chk("wrap.reInstr", instrW, 16'h4100);

      // ---- randomized traffic against the reference model ----
      doReset("rnd");
      mPc = 16'h0000; mHeldI = NOP; mDrainA = '0;
      mHalt = 0; mHeld = 0; mDrain = 0; mPend = 0;
      cnt = 0; lat = 1; pRd = 0; pAddr = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst = 1'b0;
         eRd   = !mHalt && !mHeld;
         eAddr = mDrain ? mDrainA : mPc;
         if (eRd) begin
            if (pRd && eAddr == pAddr && cnt > 0) cnt++;
            else begin cnt = 1; lat = $urandom_range(1, 4); end
            imemDone = (cnt >= lat);
            r = 16'($urandom);
            imemData = imemDone ? memWord(eAddr) : r;
            if (imemDone) cnt = 0;
         end else begin
            cnt = 0; imemDone = 1'b0; imemData = 16'($urandom);
         end
         pRd = eRd; pAddr = eAddr;
         stall    = ($urandom_range(0, 3) == 0);
         redirect = ($urandom_range(0, 19) == 0);
         r = 16'($urandom);
         redirectPC = r & 16'hFFFE;

         deliver = !redirect && (mHeld || (!mHalt && !mDrain && imemDone));
         eInstr  = !deliver ? NOP : (mHeld ? mHeldI : imemData);
         #1;
         chk($sformatf("r%0d.rd", c), {15'd0, rdA}, {15'd0, eRd});
         if (eRd) chk($sformatf("r%0d.addr", c), addrA, eAddr);
         chk($sformatf("r%0d.valid", c), {15'd0, validA}, {15'd0, deliver});
         chk($sformatf("r%0d.instr", c), instrA, eInstr);
         chk($sformatf("r%0d.curr", c), currA, mPc);
         chk($sformatf("r%0d.next", c), nextA, mPc + 16'd2);

         if (redirect) begin
            if (!imemDone && (mPend || mDrain)) begin
               if (!mDrain) mDrainA = mPc;
               mDrain = 1;
            end else mDrain = 0;
            mPc = redirectPC; mHalt = 0; mHeld = 0; mPend = 0;
         end else if (mHalt) begin
            mHalt = 1;
         end else if (mDrain) begin
            if (imemDone) mDrain = 0;
         end else if (mHeld) begin
            if (!stall) begin
               mHeld = 0; mHalt = haltWord(mHeldI); mPc = mPc + 16'd2;
            end
         end else if (imemDone) begin
            mPend = 0;
            if (!stall) begin
               mHalt = haltWord(imemData); mPc = mPc + 16'd2;
            end else begin
               mHeld = 1; mHeldI = imemData;
            end
         end else begin
            mPend = 1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
